cam_pixel_buffer: RTL and testbench

Upstream feeder for the LCD sync generator. Captures the OV7725 RGB565 byte stream, which arrives already synchronous to i_clk. Packs each byte pair into a pixel and expands it to RGB888, then buffers pixels in a FIFO. The sync generator pops pixels with its data-ready pulse, and this block drives that generator's data-valid and r/g/b inputs.

---
 rtl/cam_pixel_buffer.sv | 166 ++++++++++++++++
 tb/tb_cam_pixel_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_buffer.sv
// Camera RGB565 byte-stream capture, RGB888 expansion and pixel FIFO.
// It feeds the LCD sync generator's data-valid and r/g/b inputs.
module cam_pixel_buffer #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int START_LEVEL = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cam_vsync,
  input  logic              i_cam_href,
  input  logic              i_cam_de,
  input  logic [7:0]        i_cam_data,
  input  logic              i_pix_ready,
  input  logic              i_err_clr,
  output logic              o_stream_vld,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic [ADDR_W:0]   o_level,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ARM_LEVEL  = (ADDR_W+1)'(START_LEVEL);
  localparam logic [ADDR_W:0] LEVEL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Byte capture state
  logic        vsync_reg;
  logic        armed_reg;
  logic        phase_reg;
  logic [7:0]  hi_byte_reg;

  // FIFO state
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   level_reg;
  logic [23:0]       mem [DEPTH];
  logic [23:0]       rd_word_reg;
  logic              out_valid_reg;

  logic              stream_vld_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  logic        vsync_rise;
  logic        byte_acc;
  logic        wr_req;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        wr_en;
  logic [15:0] pixel;
  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [23:0] wr_word;

  assign vsync_rise = i_cam_vsync & ~vsync_reg;
  assign byte_acc   = armed_reg & i_cam_href & i_cam_de & ~vsync_rise;
  assign wr_req     = byte_acc & phase_reg;

  assign pixel   = {hi_byte_reg, i_cam_data};
  assign r5      = pixel[15:11];
  assign g6      = pixel[10:5];
  assign b5      = pixel[4:0];
  // Replicate the top bits into the new LSBs so full scale maps to 0xFF
  assign wr_word = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == FULL_LEVEL);
  assign pop        = i_pix_ready & ~fifo_empty;
  assign wr_en      = wr_req & (~fifo_full | pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_reg   <= 1'b0;
      armed_reg   <= 1'b0;
      phase_reg   <= 1'b0;
      hi_byte_reg <= '0;
    end else begin
      vsync_reg <= i_cam_vsync;
      if (vsync_rise) begin
        armed_reg <= 1'b1;
        phase_reg <= 1'b0;
      end else if (!i_cam_href) begin
        phase_reg <= 1'b0;
      end else if (byte_acc) begin
        if (!phase_reg) begin
          hi_byte_reg <= i_cam_data;
          phase_reg   <= 1'b1;
        end else begin
          phase_reg <= 1'b0;
        end
      end
    end
  end

  // Storage has no reset so it maps onto block RAM; read is read-first,
  // which keeps a same-cycle full write+pop on the shared address correct.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_word;
    end
    if (pop) begin
      rd_word_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
        out_valid_reg <= 1'b1;
      end
      if (wr_en && !pop) begin
        level_reg <= level_reg + LEVEL_ONE;
      end else if (!wr_en && pop) begin
        level_reg <= level_reg - LEVEL_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stream_vld_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      // Sticky: downstream counters must keep running through blanking
      if (level_reg >= ARM_LEVEL) begin
        stream_vld_reg <= 1'b1;
      end
      if (wr_req && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (i_err_clr) begin
        overflow_reg <= 1'b0;
      end
      if (i_pix_ready && fifo_empty) begin
        underflow_reg <= 1'b1;
      end else if (i_err_clr) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  // Gate the uninitialised read register until the first pop after reset
  assign o_r          = out_valid_reg ? rd_word_reg[23:16] : 8'h00;
  assign o_g          = out_valid_reg ? rd_word_reg[15:8]  : 8'h00;
  assign o_b          = out_valid_reg ? rd_word_reg[7:0]   : 8'h00;
  assign o_level      = level_reg;
  assign o_stream_vld = stream_vld_reg;
  assign o_overflow   = overflow_reg;
  assign o_underflow  = underflow_reg;

endmodule

// File: tb/tb_cam_pixel_buffer.sv
// Randomized bench for cam_pixel_buffer against a queue-based pixel model.
module tb_cam_pixel_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, href, de, ready, clr;
  logic [7:0]  data;
  logic        stream_vld, overflow, underflow;
  logic [7:0]  r, g, b;
  logic [10:0] level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cam_pixel_buffer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cam_vsync(vs), .i_cam_href(href), .i_cam_de(de), .i_cam_data(data),
    .i_pix_ready(ready), .i_err_clr(clr),
    .o_stream_vld(stream_vld), .o_r(r), .o_g(g), .o_b(b),
    .o_level(level), .o_overflow(overflow), .o_underflow(underflow)
  );

  // Reference model
  logic [23:0] q[$];
  bit          m_armed, m_phase, m_vs_prev, m_vld, m_ovf, m_unf;
  logic [7:0]  m_hi;
  logic [23:0] m_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  task automatic model_reset();
    q.delete();
    m_armed = 0; m_phase = 0; m_vs_prev = 0; m_vld = 0;
    m_ovf = 0; m_unf = 0; m_hi = 8'h00; m_last = 24'h0;
  endtask

  task automatic model_step();
    int n = q.size();
    bit rise = vs && !m_vs_prev;
    bit accept = m_armed && href && de && !rise;
    bit wr = 0;
    bit popped = ready && (n > 0);
    logic [23:0] w = 24'h0;
    m_vs_prev = vs;
    if (rise) begin
      m_armed = 1; m_phase = 0;
    end else if (!href) begin
      m_phase = 0;
    end else if (accept) begin
      if (!m_phase) begin
        m_hi = data; m_phase = 1;
      end else begin
        w = expand({m_hi, data}); wr = 1; m_phase = 0;
      end
    end
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (ready && n == 0) m_unf = 1;
    if (n >= 16) m_vld = 1;
    if (popped) m_last = q.pop_front();
    if (wr) begin
      if (n < 1024 || popped) q.push_back(w);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    chk(tag, {27'h0, stream_vld, r, g, b, level, overflow, underflow},
             {27'h0, m_vld, m_last, 11'(q.size()), m_ovf, m_unf});
  endtask

  task automatic tick(input logic v, input logic h, input logic d, input logic [7:0] dat,
                      input logic rdy, input logic c);
    vs = v; href = h; de = d; data = dat; ready = rdy; clr = c;
    @(posedge clk);
    model_step();
    #1;
    compare_all("cycle");
  endtask

  task automatic send_px(input logic [15:0] p, input logic rdy_lo);
    logic [7:0] hb, lb;
    hb = p[15:8];
    lb = p[7:0];
    tick(0, 1, 1, hb, 0, 0);
    tick(0, 1, 1, lb, rdy_lo, 0);
  endtask

  task automatic idle(input logic rdy);
    tick(0, 0, 0, 8'h00, rdy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all("reset_async");
    chk("reset_level", {53'h0, level}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [23:0] last_px;
  int writes, cyc;

  initial begin
    rst_n = 1'b1; vs = 0; href = 0; de = 0; data = 8'h00; ready = 0; clr = 0;
    model_reset();
    #1;
    do_reset();

    // 1: reset mid-stream, then bytes ignored until vsync
    tick(1, 0, 0, 8'h00, 0, 0);
    idle(0);
    for (int i = 0; i < 5; i++) send_px(16'($urandom), 0);
    chk("pre_reset_level", {53'h0, level}, 64'd5);
    tick(0, 1, 1, 8'hAB, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) send_px(16'($urandom), 0);
    chk("unarmed_level", {53'h0, level}, 64'd0);

    // 2: colour expansion
    tick(1, 0, 0, 8'h00, 0, 0);
    idle(0);
    send_px(16'hF800, 0);
    send_px(16'h07E0, 0);
    send_px(16'h001F, 0);
    send_px(16'h8410, 0);
    idle(0);
    idle(1); chk("red",   {40'h0, r, g, b}, 64'hFF0000);
    idle(1); chk("green", {40'h0, r, g, b}, 64'h00FF00);
    idle(1); chk("blue",  {40'h0, r, g, b}, 64'h0000FF);
    idle(1); chk("grey",  {40'h0, r, g, b}, 64'h848284);

    // 3: href drop discards held high byte
    tick(0, 1, 1, 8'hF8, 0, 0);
    idle(0);
    send_px(16'h001F, 0);
    chk("href_drop_level", {53'h0, level}, 64'd1);
    idle(1); chk("href_drop_px", {40'h0, r, g, b}, 64'h0000FF);

    // 4: arming of stream valid, then underflow
    for (int i = 0; i < 16; i++) send_px(16'($urandom), 0);
    chk("lvl16", {53'h0, level}, 64'd16);
    chk("vld_not_yet", {63'h0, stream_vld}, 64'd0);
    idle(0);
    chk("vld_set", {63'h0, stream_vld}, 64'd1);
    for (int i = 0; i < 19; i++) idle(1);
    last_px = q.size() == 0 ? m_last : 24'h0;
    chk("underflow", {63'h0, underflow}, 64'd1);
    chk("vld_holds", {63'h0, stream_vld}, 64'd1);
    chk("hold_last", {40'h0, r, g, b}, {40'h0, last_px});

    // 5: full FIFO, overflow and its clear
    tick(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 1024; i++) send_px(16'($urandom), 0);
    chk("full_level", {53'h0, level}, 64'd1024);
    send_px(16'h1234, 0);
    chk("overflow", {63'h0, overflow}, 64'd1);
    chk("full_hold", {53'h0, level}, 64'd1024);
    tick(0, 0, 0, 8'h00, 0, 1);
    chk("ovf_clear", {63'h0, overflow}, 64'd0);
    send_px(16'h5678, 1);
    chk("full_rw_level", {53'h0, level}, 64'd1024);
    chk("full_rw_ovf", {63'h0, overflow}, 64'd0);
    for (int i = 0; i < 1024; i++) idle(1);
    chk("drained", {53'h0, level}, 64'd0);
    tick(0, 0, 0, 8'h00, 0, 1);

    // 6: sustained streaming with pointer wrap
    writes = 0;
    cyc = 0;
    while (writes < 3000 && cyc < 40000) begin
      logic [15:0] p;
      p = 16'($urandom);
      for (int k = 0; k < 2; k++) begin
        logic [7:0] bv;
        bv = (k == 0) ? p[15:8] : p[7:0];
        while ($urandom_range(3) == 0) begin
          tick(0, 1, 0, 8'($urandom), (q.size() > 8) && ($urandom_range(3) != 0), 0);
          cyc++;
        end
        tick(0, 1, 1, bv, (q.size() > 8) && ($urandom_range(3) != 0), 0);
        cyc++;
      end
      writes++;
    end
    chk("stream_budget", {63'h0, writes >= 3000}, 64'd1);
    chk("stream_ovf", {63'h0, overflow}, 64'd0);
    chk("stream_unf", {63'h0, underflow}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
